psum_collector: RTL

//  Receiving end of the systolic array's bottom edge: captures the partial sums leaving
//  the out_down port of each bottom-row PE. Columns arrive skewed in time, column j

---
 rtl/psum_collector_if.sv | 26 ++
 rtl/psum_collector.sv | 75 +++++++
 2 files changed

// File: rtl/psum_collector_if.sv
// psum_collector_if: column inputs from the array bottom edge and row output toward the output buffer
interface psum_collector_if #(
    parameter int N  = 5,
    parameter int DW = 16,
    parameter int RW = 8
);
    logic            clear;
    logic [RW-1:0]   cfg_rows;
    logic [N-1:0]    col_valid;
    logic [N*DW-1:0] col_data;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_data;
    logic [RW-1:0]   out_row;
    logic            out_last;
    logic            almost_full;
    logic            overflow;
    modport master (
        output clear, cfg_rows, col_valid, col_data, out_ready,
        input  out_valid, out_data, out_row, out_last, almost_full, overflow
    );
    modport slave (
        input  clear, cfg_rows, col_valid, col_data, out_ready,
        output out_valid, out_data, out_row, out_last, almost_full, overflow
    );
endinterface

// File: rtl/psum_collector.sv
// psum_collector: realigns skewed bottom-row psum columns into whole rows via per-column rings
module psum_collector #(
    parameter int N     = 5,
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int RW    = 8
) (
    input logic clk,
    input logic rst,
    psum_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [DW-1:0]   mem_q [N][DEPTH];
    logic [PW-1:0]   wptr_q [N];
    logic [PW-1:0]   wptr_d [N];
    logic [PW-1:0]   occ [N];
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [RW-1:0]   row_q, row_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    nonempty, full, near, wr;
    logic [N*DW-1:0] data;
    logic            valid, last, pop;
    always_comb begin
        nonempty = '0;
        full = '0;
        near = '0;
        wr = '0;
        data = '0;
        for (int j = 0; j < N; j++) begin
            occ[j] = wptr_q[j] - rptr_q;
            nonempty[j] = occ[j] != '0;
            full[j] = occ[j] == PW'(DEPTH);
            near[j] = occ[j] >= PW'(DEPTH - N);
            wr[j] = bus.col_valid[j] & ~full[j] & ~bus.clear;
            wptr_d[j] = bus.clear ? '0 : wptr_q[j] + PW'(wr[j]);
        end
        valid = &nonempty;
        last = valid && row_q == bus.cfg_rows - RW'(1);
        pop = valid & bus.out_ready;
        for (int j = 0; j < N; j++)
            data[j*DW +: DW] = valid ? mem_q[j][rptr_q[AW-1:0]] : '0;
        rptr_d = bus.clear ? '0 : rptr_q + PW'(pop);
        row_d = bus.clear ? '0 : pop ? (last ? '0 : row_q + RW'(1)) : row_q;
        // fullness is judged on pre-cycle occupancy, so a same-cycle pop never rescues a write
        ovf_d = bus.clear ? 1'b0 : ovf_q | (|(bus.col_valid & full));
    end
    assign bus.out_valid   = valid;
    assign bus.out_data    = data;
    assign bus.out_row     = row_q;
    assign bus.out_last    = last;
    assign bus.almost_full = |near;
    assign bus.overflow    = ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q <= '0;
            row_q  <= '0;
            ovf_q  <= 1'b0;
            for (int j = 0; j < N; j++) begin
                wptr_q[j] <= '0;
                for (int k = 0; k < DEPTH; k++)
                    mem_q[j][k] <= '0;
            end
        end else begin
            rptr_q <= rptr_d;
            row_q  <= row_d;
            ovf_q  <= ovf_d;
            for (int j = 0; j < N; j++) begin
                wptr_q[j] <= wptr_d[j];
                if (wr[j])
                    mem_q[j][wptr_q[j][AW-1:0]] <= bus.col_data[j*DW +: DW];
            end
        end
    end
endmodule
